// File: rtl/uart_cen.sv
// rtl/uart_cen.sv - cen-timed 8N1 full-duplex UART with per-direction prescaler and sub-tick counters.
// Build option: define UART_LOOPBACK_EN to feed the receiver from the internal uart_tx.
module uart_cen #(
  parameter logic [4:0] CLK_DIVIDER  = 5'd3,
  parameter logic [4:0] UART_DIVIDER = 5'd23
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       rx_error,
  input  logic [7:0] tx_data,
  input  logic       tx_wr,
  output logic       tx_busy,
  output logic       tx_done
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  localparam logic [4:0] PRE_LAST  = CLK_DIVIDER - 5'd1;
  localparam logic [4:0] SUB_LAST  = UART_DIVIDER - 5'd1;
  localparam logic [4:0] HALF_LAST = (UART_DIVIDER >> 1) - 5'd1;

  logic rx_in;
  logic rx_s1_q, rx_s2_q;

  state_t     rx_state_q, rx_state_d;
  logic [4:0] rx_pre_q, rx_pre_d, rx_sub_q, rx_sub_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [7:0] rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
  logic       rx_prev_q, rx_prev_d, rx_done_q, rx_done_d, rx_error_q, rx_error_d;
  logic       rx_sub_tick, rx_bit_tick;

  state_t     tx_state_q, tx_state_d;
  logic [4:0] tx_pre_q, tx_pre_d, tx_sub_q, tx_sub_d;
  logic [2:0] tx_bit_q, tx_bit_d;
  logic [7:0] tx_sh_q, tx_sh_d;
  logic       uart_tx_q, uart_tx_d, tx_busy_q, tx_busy_d, tx_done_q, tx_done_d;
  logic       tx_sub_tick, tx_bit_tick;

`ifdef UART_LOOPBACK_EN
  logic unused_uart_rx;
  assign unused_uart_rx = uart_rx;
  assign rx_in = uart_tx_q;
`else
  assign rx_in = uart_rx;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
    end else begin
      rx_s1_q <= rx_in;
      rx_s2_q <= rx_s1_q;
    end
  end

  assign rx_sub_tick = cen && (rx_pre_q == PRE_LAST);
  assign rx_bit_tick = rx_sub_tick && (rx_sub_q == SUB_LAST);

  always_comb begin
    rx_state_d = rx_state_q;
    rx_pre_d   = rx_pre_q;
    rx_sub_d   = rx_sub_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_prev_d  = rx_prev_q;
    rx_done_d  = 1'b0;
    rx_error_d = 1'b0;
    if (cen) begin
      rx_prev_d = rx_s2_q;
      rx_pre_d  = rx_sub_tick ? 5'd0 : rx_pre_q + 5'd1;
      if (rx_sub_tick) rx_sub_d = (rx_sub_q == SUB_LAST) ? 5'd0 : rx_sub_q + 5'd1;
    end
    case (rx_state_q)
      S_IDLE: begin
        if (cen && rx_prev_q && !rx_s2_q) begin
          rx_state_d = S_START;
          rx_pre_d   = 5'd0;
          rx_sub_d   = 5'd0;
        end
      end
      S_START: begin
        // Mid-start sample realigns the sub-tick counter so data samples land mid-bit.
        if (rx_sub_tick && rx_sub_q == HALF_LAST) begin
          if (rx_s2_q) begin
            rx_state_d = S_IDLE;
          end else begin
            rx_state_d = S_DATA;
            rx_sub_d   = 5'd0;
            rx_bit_d   = 3'd0;
          end
        end
      end
      S_DATA: begin
        if (rx_bit_tick) begin
          rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
          rx_bit_d = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
        end
      end
      default: begin
        if (rx_bit_tick) begin
          rx_data_d  = rx_sh_q;
          rx_done_d  = rx_s2_q;
          rx_error_d = !rx_s2_q;
          rx_state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_q <= S_IDLE;
      rx_pre_q   <= 5'd0;
      rx_sub_q   <= 5'd0;
      rx_bit_q   <= 3'd0;
      rx_sh_q    <= 8'd0;
      rx_data_q  <= 8'd0;
      rx_prev_q  <= 1'b1;
      rx_done_q  <= 1'b0;
      rx_error_q <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_pre_q   <= rx_pre_d;
      rx_sub_q   <= rx_sub_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_prev_q  <= rx_prev_d;
      rx_done_q  <= rx_done_d;
      rx_error_q <= rx_error_d;
    end
  end

  assign tx_sub_tick = cen && (tx_pre_q == PRE_LAST);
  assign tx_bit_tick = tx_sub_tick && (tx_sub_q == SUB_LAST);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_pre_d   = tx_pre_q;
    tx_sub_d   = tx_sub_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    uart_tx_d  = uart_tx_q;
    tx_busy_d  = tx_busy_q;
    tx_done_d  = 1'b0;
    if (cen) begin
      tx_pre_d = tx_sub_tick ? 5'd0 : tx_pre_q + 5'd1;
      if (tx_sub_tick) tx_sub_d = (tx_sub_q == SUB_LAST) ? 5'd0 : tx_sub_q + 5'd1;
    end
    case (tx_state_q)
      S_IDLE: begin
        // Write is accepted on any clk, independent of cen.
        if (tx_wr) begin
          tx_sh_d    = tx_data;
          tx_busy_d  = 1'b1;
          uart_tx_d  = 1'b0;
          tx_pre_d   = 5'd0;
          tx_sub_d   = 5'd0;
          tx_state_d = S_START;
        end
      end
      S_START: begin
        if (tx_bit_tick) begin
          uart_tx_d  = tx_sh_q[0];
          tx_bit_d   = 3'd0;
          tx_state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (tx_bit_tick) begin
          if (tx_bit_q == 3'd7) begin
            uart_tx_d  = 1'b1;
            tx_state_d = S_STOP;
          end else begin
            uart_tx_d = tx_sh_q[1];
            tx_sh_d   = {1'b0, tx_sh_q[7:1]};
            tx_bit_d  = tx_bit_q + 3'd1;
          end
        end
      end
      default: begin
        if (tx_bit_tick) begin
          tx_busy_d  = 1'b0;
          tx_done_d  = 1'b1;
          tx_state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= S_IDLE;
      tx_pre_q   <= 5'd0;
      tx_sub_q   <= 5'd0;
      tx_bit_q   <= 3'd0;
      tx_sh_q    <= 8'd0;
      uart_tx_q  <= 1'b1;
      tx_busy_q  <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_pre_q   <= tx_pre_d;
      tx_sub_q   <= tx_sub_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      uart_tx_q  <= uart_tx_d;
      tx_busy_q  <= tx_busy_d;
      tx_done_q  <= tx_done_d;
    end
  end

  assign uart_tx  = uart_tx_q;
  assign rx_data  = rx_data_q;
  assign rx_done  = rx_done_q;
  assign rx_error = rx_error_q;
  assign tx_busy  = tx_busy_q;
  assign tx_done  = tx_done_q;

endmodule

// File: tb/tb_uart_cen.sv
// tb/tb_uart_cen.sv - scoreboard bench for uart_cen: serial TX decode, RX frame drive, cen gating.
module tb_uart_cen;

  logic       clk = 1'b0;
  logic       rst, cen, uart_rx, tx_wr;
  logic [7:0] tx_data;
  logic       uart_tx, rx_done, rx_error, tx_busy, tx_done;
  logic [7:0] rx_data;

  int pass_cnt = 0, check_cnt = 0;
  int rx_done_cnt = 0, rx_err_cnt = 0, tx_done_cnt = 0, tx_frames = 0;
  int bit_clks = 69;
  bit cen_div4 = 1'b0;
  logic [1:0] cen_cnt = 2'd0;
  logic [7:0] rx_exp[$];
  logic [7:0] tx_exp[$];

  uart_cen dut (
    .clk(clk), .rst(rst), .cen(cen), .uart_rx(uart_rx), .uart_tx(uart_tx),
    .rx_data(rx_data), .rx_done(rx_done), .rx_error(rx_error),
    .tx_data(tx_data), .tx_wr(tx_wr), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cen_cnt = cen_cnt + 2'd1;
    cen = cen_div4 ? (cen_cnt == 2'd0) : 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else pass_cnt++;
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (rx_done || rx_error) check("rx_excl", rx_done & rx_error, 0);
      if (rx_done) begin
        rx_done_cnt++;
        check("rx_pending", rx_exp.size() > 0, 1);
        if (rx_exp.size() > 0) check("rx_data", rx_data, rx_exp.pop_front());
      end
      if (rx_error) rx_err_cnt++;
      if (tx_done) tx_done_cnt++;
    end
  end

  initial begin : tx_mon
    logic prev;
    logic [7:0] b;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && prev && !uart_tx) begin
        repeat (bit_clks / 2) @(negedge clk);
        check("tx_start", uart_tx, 0);
        for (int i = 0; i < 8; i++) begin
          repeat (bit_clks) @(negedge clk);
          b[i] = uart_tx;
        end
        repeat (bit_clks) @(negedge clk);
        check("tx_stop", uart_tx, 1);
        tx_frames++;
        check("tx_pending", tx_exp.size() > 0, 1);
        if (tx_exp.size() > 0) check("tx_byte", b, tx_exp.pop_front());
      end
      prev = uart_tx;
    end
  end

  task automatic send_rx(input logic [7:0] d, input logic stop);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    if (stop) rx_exp.push_back(d);
    for (int i = 0; i < 10; i++) begin
      uart_rx = f[i];
      repeat (69) @(negedge clk);
    end
    uart_rx = 1'b1;
  endtask

  initial begin
    int n, e, f0, t0;
    logic [9:0] frame;
    rst = 1'b1; tx_wr = 1'b0; tx_data = 8'h00; uart_rx = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_tx", uart_tx, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_tx_done", tx_done, 0);
    check("rst_rx_done", rx_done, 0);
    check("rst_rx_err", rx_error, 0);
    check("rst_rx_data", rx_data, 0);
    rst = 1'b0;

    repeat (2000) @(negedge clk);
    check("idle_rx_done", rx_done_cnt, 0);
    check("idle_rx_err", rx_err_cnt, 0);
    check("idle_tx", uart_tx, 1);
    check("idle_busy", tx_busy, 0);

    tx_data = 8'hA5;
    tx_exp.push_back(8'hA5);
    tx_wr = 1'b1;
    @(negedge clk);
    tx_wr = 1'b0;
    check("tx_busy_rise", tx_busy, 1);
    check("tx_start_bit", uart_tx, 0);
    frame = {1'b1, 8'hA5, 1'b0};
    for (int k = 1; k <= 700; k++) begin
      @(negedge clk);
      if (k < 690 && k % 69 == 34) check("tx_bit", uart_tx, frame[k / 69]);
      if (k == 68) check("tx_start_end", uart_tx, 0);
      if (k == 69) check("tx_bit0_begin", uart_tx, 1);
      if (k == 689) begin
        check("tx_busy_689", tx_busy, 1);
        check("tx_done_689", tx_done, 0);
      end
      if (k == 690) begin
        check("tx_done_690", tx_done, 1);
        check("tx_busy_690", tx_busy, 0);
      end
      if (k == 691) check("tx_done_691", tx_done, 0);
    end
    check("tx_done_cnt", tx_done_cnt, 1);
    check("tx_frames_a5", tx_frames, 1);

    n = rx_done_cnt; e = rx_err_cnt;
    send_rx(8'h3C, 1'b1);
    check("rx_3c_done", rx_done_cnt, n + 1);
    check("rx_3c_err", rx_err_cnt, e);
    check("rx_3c_data", rx_data, 8'h3C);

    n = rx_done_cnt; e = rx_err_cnt;
    send_rx(8'h3C, 1'b0);
    repeat (20) @(negedge clk);
    check("rx_ferr_err", rx_err_cnt, e + 1);
    check("rx_ferr_done", rx_done_cnt, n);
    check("rx_ferr_data", rx_data, 8'h3C);

    n = rx_done_cnt; e = rx_err_cnt;
    uart_rx = 1'b0;
    repeat (10) @(negedge clk);
    uart_rx = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch_done", rx_done_cnt, n);
    check("glitch_err", rx_err_cnt, e);
    send_rx(8'h55, 1'b1);
    check("rx_55_done", rx_done_cnt, n + 1);
    check("rx_55_err", rx_err_cnt, e);
    check("rx_55_data", rx_data, 8'h55);

    cen_div4 = 1'b1;
    bit_clks = 276;
    repeat (8) @(negedge clk);
    f0 = tx_frames; t0 = tx_done_cnt;
    tx_data = 8'h5A;
    tx_exp.push_back(8'h5A);
    tx_wr = 1'b1;
    @(negedge clk);
    tx_wr = 1'b0;
    check("cen4_busy", tx_busy, 1);
    repeat (276 * 3) @(negedge clk);
    check("cen4_mid_busy", tx_busy, 1);
    tx_data = 8'hFF;
    tx_wr = 1'b1;
    @(negedge clk);
    tx_wr = 1'b0;
    tx_data = 8'h00;
    for (int i = 0; i < 4000 && tx_busy; i++) @(negedge clk);
    check("cen4_busy_drop", tx_busy, 0);
    repeat (600) @(negedge clk);
    check("cen4_frames", tx_frames, f0 + 1);
    check("cen4_tx_done", tx_done_cnt, t0 + 1);
    check("cen4_line_idle", uart_tx, 1);
    check("tx_exp_empty", tx_exp.size(), 0);
    check("rx_exp_empty", rx_exp.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
